// File: rtl/mem_arbiter.sv
// Memory port arbiter: grants one of CPU / front panel / data-break per access,
// drives a single-strobe memory access and returns read data after MEM_LAT cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned DB_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              fp_req,
    input  logic              fp_we,
    input  logic [ADDR_W-1:0] fp_addr,
    input  logic [DATA_W-1:0] fp_wdata,
    output logic              fp_gnt,
    output logic              fp_rvalid,

    input  logic              db_req,
    input  logic              db_we,
    input  logic [ADDR_W-1:0] db_addr,
    input  logic [DATA_W-1:0] db_wdata,
    output logic              db_gnt,
    output logic              db_rvalid,

    input  logic              halted,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned BURST_W = $clog2(DB_BURST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_FP, OWN_DB} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d, win;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic [BURST_W-1:0]  burst_q, burst_d;

    logic                cpu_gnt_d, fp_gnt_d, db_gnt_d;
    logic                cpu_rvalid_d, fp_rvalid_d, db_rvalid_d;
    logic                mem_en_d, mem_we_d, busy_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d, rdata_d;

    // Winner select: a saturated burst counter forces the CPU in ahead of data-break
    always_comb begin
        win = OWN_NONE;
        if (cpu_req && (burst_q >= BURST_W'(DB_BURST))) begin
            win = OWN_CPU;
        end else if (db_req) begin
            win = OWN_DB;
        end else if (fp_req && halted) begin
            win = OWN_FP;
        end else if (cpu_req) begin
            win = OWN_CPU;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wait_d       = wait_q;
        burst_d      = burst_q;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = mem_we;
        rdata_d      = rdata;
        mem_en_d     = 1'b0;
        cpu_gnt_d    = 1'b0;
        fp_gnt_d     = 1'b0;
        db_gnt_d     = 1'b0;
        cpu_rvalid_d = 1'b0;
        fp_rvalid_d  = 1'b0;
        db_rvalid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win != OWN_NONE) begin
                    owner_d  = win;
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    case (win)
                        OWN_DB: begin
                            mem_addr_d  = db_addr;
                            mem_wdata_d = db_wdata;
                            mem_we_d    = db_we;
                            db_gnt_d    = 1'b1;
                            burst_d     = cpu_req ? burst_q + BURST_W'(1) : '0;
                        end
                        OWN_FP: begin
                            mem_addr_d  = fp_addr;
                            mem_wdata_d = fp_wdata;
                            mem_we_d    = fp_we;
                            fp_gnt_d    = 1'b1;
                        end
                        default: begin
                            mem_addr_d  = cpu_addr;
                            mem_wdata_d = cpu_wdata;
                            mem_we_d    = cpu_we;
                            cpu_gnt_d   = 1'b1;
                            burst_d     = '0;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_d = DONE;
                end else begin
                    wait_d  = CNT_W'(MEM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q - CNT_W'(1);
                if (wait_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // rvalid and rdata load on the edge entering DONE so both are seen in DONE
        if ((state_d == DONE) && (state_q != DONE)) begin
            cpu_rvalid_d = (owner_q == OWN_CPU);
            fp_rvalid_d  = (owner_q == OWN_FP);
            db_rvalid_d  = (owner_q == OWN_DB);
            if (!mem_we) begin
                rdata_d = mem_rdata;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            wait_q     <= '0;
            burst_q    <= '0;
            cpu_gnt    <= 1'b0;
            fp_gnt     <= 1'b0;
            db_gnt     <= 1'b0;
            cpu_rvalid <= 1'b0;
            fp_rvalid  <= 1'b0;
            db_rvalid  <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_q     <= wait_d;
            burst_q    <= burst_d;
            cpu_gnt    <= cpu_gnt_d;
            fp_gnt     <= fp_gnt_d;
            db_gnt     <= db_gnt_d;
            cpu_rvalid <= cpu_rvalid_d;
            fp_rvalid  <= fp_rvalid_d;
            db_rvalid  <= db_rvalid_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            rdata      <= rdata_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT = 2, DB_BURST = 4).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, fp_req, fp_we, db_req, db_we, halted;
    logic [14:0] cpu_addr, fp_addr, db_addr;
    logic [11:0] cpu_wdata, fp_wdata, db_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, fp_gnt, fp_rvalid, db_gnt, db_rvalid;
    logic        mem_en, mem_we, busy;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata, rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(15), .DATA_W(12), .MEM_LAT(2), .DB_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .fp_req(fp_req), .fp_we(fp_we), .fp_addr(fp_addr), .fp_wdata(fp_wdata),
        .fp_gnt(fp_gnt), .fp_rvalid(fp_rvalid),
        .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
        .db_gnt(db_gnt), .db_rvalid(db_rvalid),
        .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({cpu_gnt, cpu_rvalid, fp_gnt, fp_rvalid, db_gnt, db_rvalid, mem_en, mem_we, busy} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0", {cpu_gnt, cpu_rvalid, fp_gnt, fp_rvalid, db_gnt, db_rvalid, mem_en, mem_we, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 39'b0) begin
            failures++;
            $display("FAIL reset_data: got %o %o %o want 0", mem_addr, mem_wdata, rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        mem_rdata = 12'o7402;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'o00200; cpu_wdata = 12'o0000;
        tick(); // N+1
        checks++;
        if ({cpu_gnt, mem_en, mem_we, busy, db_gnt, fp_gnt} !== 6'b110100) begin
            failures++;
            $display("FAIL cpu_rd_issue: got gnt/en/we/busy/db/fp=%b want 110100", {cpu_gnt, mem_en, mem_we, busy, db_gnt, fp_gnt});
        end
        checks++;
        if (mem_addr !== 15'o00200) begin
            failures++;
            $display("FAIL cpu_rd_addr: got %o want 00200", mem_addr);
        end
        cpu_req = 1'b0;
        tick(); // N+2
        checks++;
        if ({cpu_gnt, mem_en, cpu_rvalid, busy} !== 4'b0001) begin
            failures++;
            $display("FAIL cpu_rd_wait: got gnt/en/rvalid/busy=%b want 0001", {cpu_gnt, mem_en, cpu_rvalid, busy});
        end
        tick(); // N+3
        checks++;
        if ({cpu_rvalid, busy} !== 2'b11 || rdata !== 12'o7402) begin
            failures++;
            $display("FAIL cpu_rd_done: got rvalid/busy=%b rdata=%o want 11 7402", {cpu_rvalid, busy}, rdata);
        end
        tick(); // N+4
        checks++;
        if ({cpu_rvalid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL cpu_rd_idle: got rvalid/busy=%b want 00", {cpu_rvalid, busy});
        end
    endtask

    task automatic test_simultaneous();
        mem_rdata = 12'o5555;
        db_req = 1'b1; db_we = 1'b0; db_addr = 15'o04000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'o00400;
        tick(); // 1
        checks++;
        if ({db_gnt, cpu_gnt} !== 2'b10 || mem_addr !== 15'o04000) begin
            failures++;
            $display("FAIL sim_db_gnt: got db/cpu=%b addr=%o want 10 04000", {db_gnt, cpu_gnt}, mem_addr);
        end
        db_req = 1'b0;
        tick(); // 2
        tick(); // 3
        checks++;
        if ({db_rvalid, cpu_rvalid} !== 2'b10 || rdata !== 12'o5555) begin
            failures++;
            $display("FAIL sim_db_rvalid: got db/cpu=%b rdata=%o want 10 5555", {db_rvalid, cpu_rvalid}, rdata);
        end
        mem_rdata = 12'o1111;
        tick(); // 4
        checks++;
        if ({cpu_gnt, busy} !== 2'b00) begin
            failures++;
            $display("FAIL sim_idle4: got gnt/busy=%b want 00", {cpu_gnt, busy});
        end
        tick(); // 5
        checks++;
        if ({cpu_gnt, db_gnt} !== 2'b10 || mem_addr !== 15'o00400) begin
            failures++;
            $display("FAIL sim_cpu_gnt: got cpu/db=%b addr=%o want 10 00400", {cpu_gnt, db_gnt}, mem_addr);
        end
        cpu_req = 1'b0;
        tick(); // 6
        tick(); // 7
        checks++;
        if (cpu_rvalid !== 1'b1 || rdata !== 12'o1111) begin
            failures++;
            $display("FAIL sim_cpu_rvalid: got rvalid=%b rdata=%o want 1 1111", cpu_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_fp_gating();
        mem_rdata = 12'o4321;
        halted = 1'b0;
        fp_req = 1'b1; fp_we = 1'b0; fp_addr = 15'o07770;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({fp_gnt, busy} !== 2'b00) begin
                failures++;
                $display("FAIL fp_gated cycle %0d: got gnt/busy=%b want 00", i, {fp_gnt, busy});
            end
        end
        halted = 1'b1;
        tick();
        checks++;
        if ({fp_gnt, mem_en} !== 2'b11 || mem_addr !== 15'o07770) begin
            failures++;
            $display("FAIL fp_ungated_gnt: got gnt/en=%b addr=%o want 11 07770", {fp_gnt, mem_en}, mem_addr);
        end
        fp_req = 1'b0;
        tick();
        tick();
        checks++;
        if (fp_rvalid !== 1'b1 || rdata !== 12'o4321) begin
            failures++;
            $display("FAIL fp_read_rvalid: got rvalid=%b rdata=%o want 1 4321", fp_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_fp_deposit();
        mem_rdata = 12'o7777;
        fp_req = 1'b1; fp_we = 1'b1; fp_addr = 15'o10017; fp_wdata = 12'o1234;
        tick();
        checks++;
        if ({fp_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 15'o10017 || mem_wdata !== 12'o1234) begin
            failures++;
            $display("FAIL dep_issue: got gnt/en/we=%b addr=%o wdata=%o want 111 10017 1234", {fp_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        fp_req = 1'b0; fp_addr = 15'o0; fp_wdata = 12'o0;
        tick();
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 15'o10017 || mem_wdata !== 12'o1234) begin
            failures++;
            $display("FAIL dep_hold: got en=%b addr=%o wdata=%o want 0 10017 1234", mem_en, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (fp_rvalid !== 1'b1 || rdata !== 12'o4321) begin
            failures++;
            $display("FAIL dep_ack: got rvalid=%b rdata=%o want 1 4321", fp_rvalid, rdata);
        end
        tick();
        halted = 1'b0; fp_we = 1'b0;
    endtask

    task automatic test_fairness();
        logic exp_cpu;
        db_req = 1'b1; db_we = 1'b0; db_addr = 15'o00010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'o00020;
        for (int g = 0; g < 10; g++) begin
            exp_cpu = ((g % 5) == 4);
            tick();
            checks++;
            if ({cpu_gnt, db_gnt} !== {exp_cpu, ~exp_cpu}) begin
                failures++;
                $display("FAIL fair_grant %0d: got cpu/db=%b want %b", g, {cpu_gnt, db_gnt}, {exp_cpu, ~exp_cpu});
            end
            if (g == 9) begin
                db_req = 1'b0;
                cpu_req = 1'b0;
            end
            tick();
            tick();
            tick();
        end
    endtask

    task automatic test_reset_in_wait();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'o00300;
        mem_rdata = 12'o6666;
        tick();
        cpu_req = 1'b0;
        tick(); // WAIT
        reset = 1'b1;
        tick();
        checks++;
        if ({cpu_gnt, cpu_rvalid, fp_gnt, fp_rvalid, db_gnt, db_rvalid, mem_en, mem_we, busy} !== 9'b0 ||
            {mem_addr, mem_wdata, rdata} !== 39'b0) begin
            failures++;
            $display("FAIL rst_wait_outputs: got ctrl=%b addr=%o rdata=%o want 0",
                     {cpu_gnt, cpu_rvalid, fp_gnt, fp_rvalid, db_gnt, db_rvalid, mem_en, mem_we, busy}, mem_addr, rdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({cpu_rvalid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_wait_no_rvalid: got rvalid/busy=%b want 00", {cpu_rvalid, busy});
        end
        mem_rdata = 12'o0707;
        cpu_req = 1'b1; cpu_addr = 15'o00500;
        tick();
        checks++;
        if ({cpu_gnt, mem_en} !== 2'b11 || mem_addr !== 15'o00500) begin
            failures++;
            $display("FAIL rst_fresh_gnt: got gnt/en=%b addr=%o want 11 00500", {cpu_gnt, mem_en}, mem_addr);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || rdata !== 12'o0707) begin
            failures++;
            $display("FAIL rst_fresh_rvalid: got rvalid=%b rdata=%o want 1 0707", cpu_rvalid, rdata);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fp_req = 1'b0; fp_we = 1'b0; fp_addr = '0; fp_wdata = '0;
        db_req = 1'b0; db_we = 1'b0; db_addr = '0; db_wdata = '0;
        halted = 1'b0; mem_rdata = '0;
        #1;
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_fp_gating();
        test_fp_deposit();
        test_fairness();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
